// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts bubbles on load-use, supports flush/hold, counts bubbles.
module id_ex_stage #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic             id_RegWrite_i,
    input  logic             id_MemWrite_i,
    input  logic             id_ALUSrc_i,
    input  logic [4:0]       id_ALUOp_i,
    input  logic [2:0]       id_NPCOp_i,
    input  logic [1:0]       id_WDSel_i,
    input  logic [2:0]       id_DMType_i,
    input  logic [DW-1:0]    id_pc_i,
    input  logic [DW-1:0]    id_rd1_i,
    input  logic [DW-1:0]    id_rd2_i,
    input  logic [DW-1:0]    id_imm_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [4:0]       id_rd_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             ex_valid,
    output logic             ex_RegWrite,
    output logic             ex_MemWrite,
    output logic             ex_ALUSrc,
    output logic [4:0]       ex_ALUOp,
    output logic [2:0]       ex_NPCOp,
    output logic [1:0]       ex_WDSel,
    output logic [2:0]       ex_DMType,
    output logic [DW-1:0]    ex_pc,
    output logic [DW-1:0]    ex_rd1,
    output logic [DW-1:0]    ex_rd2,
    output logic [DW-1:0]    ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             load_use_stall_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    logic ex_load;
    logic hit1;
    logic hit2;
    logic kill;
    logic cap;
    logic bump;

    // x0 never carries a real dependency, so a load to x0 is ignored
    assign ex_load = ex_valid & (ex_WDSel == 2'b01) & (ex_rd != 5'd0);
    assign hit1    = id_use_rs1_i & (id_rs1_i == ex_rd);
    assign hit2    = id_use_rs2_i & (id_rs2_i == ex_rd);

    assign load_use_stall_o = id_valid_i & ~flush_i & ex_load & (hit1 | hit2);

    assign bump = ~hold_i & load_use_stall_o;
    assign kill = flush_i | bump;
    assign cap  = ~flush_i & ~hold_i & ~load_use_stall_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_ALUSrc    <= 1'b0;
            ex_ALUOp     <= '0;
            ex_NPCOp     <= '0;
            ex_WDSel     <= '0;
            ex_DMType    <= '0;
            ex_pc        <= '0;
            ex_rd1       <= '0;
            ex_rd2       <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (kill) begin
                ex_valid    <= 1'b0;
                ex_RegWrite <= 1'b0;
                ex_MemWrite <= 1'b0;
                ex_ALUSrc   <= 1'b0;
                ex_ALUOp    <= '0;
                ex_NPCOp    <= '0;
                ex_WDSel    <= '0;
                ex_DMType   <= '0;
            end else if (cap) begin
                ex_valid    <= id_valid_i;
                ex_RegWrite <= id_valid_i & id_RegWrite_i;
                ex_MemWrite <= id_valid_i & id_MemWrite_i;
                ex_ALUSrc   <= id_valid_i & id_ALUSrc_i;
                ex_ALUOp    <= id_valid_i ? id_ALUOp_i : '0;
                ex_NPCOp    <= id_valid_i ? id_NPCOp_i : '0;
                ex_WDSel    <= id_valid_i ? id_WDSel_i : '0;
                ex_DMType   <= id_valid_i ? id_DMType_i : '0;
            end
            if (cap) begin
                ex_pc  <= id_pc_i;
                ex_rd1 <= id_rd1_i;
                ex_rd2 <= id_rd2_i;
                ex_imm <= id_imm_i;
                ex_rs1 <= id_rs1_i;
                ex_rs2 <= id_rs2_i;
                ex_rd  <= id_rd_i;
            end
            if (bump && !(&bubble_cnt_o))
                bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed vectors, reference model,
// per-cycle comparison plus literal spot checks.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_rw, id_mw, id_as;
    logic [4:0] id_aop;
    logic [2:0] id_npc;
    logic [1:0] id_wd;
    logic [2:0] id_dm;
    logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic use1, use2, flush, hold;

    logic ex_valid, ex_rw, ex_mw, ex_as;
    logic [4:0] ex_aop;
    logic [2:0] ex_npc;
    logic [1:0] ex_wd;
    logic [2:0] ex_dm;
    logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic stall;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid_i(id_valid), .id_RegWrite_i(id_rw),
        .id_MemWrite_i(id_mw), .id_ALUSrc_i(id_as),
        .id_ALUOp_i(id_aop), .id_NPCOp_i(id_npc),
        .id_WDSel_i(id_wd), .id_DMType_i(id_dm),
        .id_pc_i(id_pc), .id_rd1_i(id_rd1),
        .id_rd2_i(id_rd2), .id_imm_i(id_imm),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_use_rs1_i(use1), .id_use_rs2_i(use2),
        .flush_i(flush), .hold_i(hold),
        .ex_valid(ex_valid), .ex_RegWrite(ex_rw),
        .ex_MemWrite(ex_mw), .ex_ALUSrc(ex_as),
        .ex_ALUOp(ex_aop), .ex_NPCOp(ex_npc),
        .ex_WDSel(ex_wd), .ex_DMType(ex_dm),
        .ex_pc(ex_pc), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .load_use_stall_o(stall), .bubble_cnt_o(cnt)
    );

    typedef struct packed {
        logic v, rw, mw, as;
        logic [4:0] aop;
        logic [2:0] npc;
        logic [1:0] wd;
        logic [2:0] dm;
        logic [DW-1:0] pc, rd1, rd2, imm;
        logic [4:0] rs1, rs2, rd;
    } ex_t;

    ex_t dut_ex;
    assign dut_ex = {ex_valid, ex_rw, ex_mw, ex_as, ex_aop, ex_npc,
                     ex_wd, ex_dm, ex_pc, ex_rd1, ex_rd2, ex_imm,
                     ex_rs1, ex_rs2, ex_rd};

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_on = 0;

    task automatic chk(input string name, input logic [159:0] act,
                       input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    // Reference model: expected EX contents and bubble count
    ex_t m;
    int  mcnt;

    function automatic logic m_stall();
        logic dep;
        dep = (use1 && id_rs1 == m.rd) || (use2 && id_rs2 == m.rd);
        return id_valid && !flush && m.v && m.wd == 2'b01
               && m.rd != 5'd0 && dep;
    endfunction

    always @(posedge clk) begin
        ex_t nxt;
        logic bubble;
        if (rst) begin
            m = '0;
            mcnt = 0;
        end else begin
            bubble = !hold && m_stall();
            nxt = m;
            if (flush || bubble) begin
                {nxt.v, nxt.rw, nxt.mw, nxt.as} = '0;
                {nxt.aop, nxt.npc, nxt.wd, nxt.dm} = '0;
            end else if (!hold) begin
                nxt = {id_valid, id_rw, id_mw, id_as, id_aop, id_npc,
                       id_wd, id_dm, id_pc, id_rd1, id_rd2, id_imm,
                       id_rs1, id_rs2, id_rd};
                if (!id_valid) begin
                    {nxt.rw, nxt.mw, nxt.as} = '0;
                    {nxt.aop, nxt.npc, nxt.wd, nxt.dm} = '0;
                end
            end
            if (bubble && mcnt < CMAX)
                mcnt = mcnt + 1;
            m = nxt;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("ex_regs", dut_ex, m);
            chk("stall", stall, m_stall());
            chk("bubble_cnt", cnt, mcnt);
            chk("valid_implies_ctrl", {ex_rw, ex_mw} & {2{~ex_valid}}, 0);
        end
    end

    int pcs = 32'h100;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] wd,
                          input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2,
                          input logic [4:0] rdx);
        id_valid = v; id_rw = 1'b1; id_mw = 1'b0; id_as = 1'b1;
        id_aop = 5'h01; id_npc = 3'd0; id_wd = wd;
        id_dm = (wd == 2'b01) ? 3'd2 : 3'd0;
        id_pc = pcs; pcs += 4;
        id_rd1 = pcs * 3; id_rd2 = pcs * 5; id_imm = pcs ^ 32'hff;
        id_rs1 = r1; use1 = u1; id_rs2 = r2; use2 = u2; id_rd = rdx;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        set_id(1'b0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        step();
        step();
        cmp_on = 1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_pc", ex_pc, 0);
        rst = 1'b0;

        // plain capture
        set_id(1'b1, 2'b00, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5);
        id_aop = 5'h03; id_rd1 = 32'h11;
        step();
        chk("cap_valid", ex_valid, 1);
        chk("cap_aluop", ex_aop, 5'h03);
        chk("cap_rd1", ex_rd1, 32'h11);
        chk("cap_rd", ex_rd, 5'd5);

        // load-use on rs1
        set_id(1'b1, 2'b01, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5);
        step();
        set_id(1'b1, 2'b00, 5'd5, 1'b1, 5'd3, 1'b1, 5'd6);
        #1 chk("lu_stall", stall, 1);
        step();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_rw", ex_rw, 0);
        chk("lu_bubble_cnt", cnt, 1);
        chk("lu_bubble_rd_kept", ex_rd, 5'd5);
        chk("lu_stall_after", stall, 0);
        step();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rd", ex_rd, 5'd6);

        // load to x0 never stalls
        set_id(1'b1, 2'b01, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0);
        step();
        set_id(1'b1, 2'b00, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7);
        #1 chk("x0_stall", stall, 0);
        step();
        chk("x0_cnt", cnt, 1);
        chk("x0_captured", ex_rd, 5'd7);

        // rs2 match without use
        set_id(1'b1, 2'b01, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
        step();
        set_id(1'b1, 2'b00, 5'd7, 1'b1, 5'd5, 1'b0, 5'd8);
        #1 chk("nouse_stall", stall, 0);
        step();
        chk("nouse_cnt", cnt, 1);

        // rs2 match with use stalls
        set_id(1'b1, 2'b01, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9);
        step();
        set_id(1'b1, 2'b00, 5'd7, 1'b1, 5'd9, 1'b1, 5'd8);
        #1 chk("rs2_stall", stall, 1);
        step();
        chk("rs2_cnt", cnt, 2);
        step();

        // flush and hold together against a load-use pair
        set_id(1'b1, 2'b01, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
        step();
        set_id(1'b1, 2'b00, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
        flush = 1'b1; hold = 1'b1;
        #1 chk("fh_stall", stall, 0);
        step();
        chk("fh_valid", ex_valid, 0);
        chk("fh_ctrl", {ex_rw, ex_wd, ex_dm}, 0);
        chk("fh_cnt", cnt, 2);
        chk("fh_rd_kept", ex_rd, 5'd5);
        flush = 1'b0; hold = 1'b0;

        // hold three cycles
        set_id(1'b1, 2'b00, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10);
        id_pc = 32'h4000;
        step();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 2'b00, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11);
            step();
            chk("hold_pc", ex_pc, 32'h4000);
        end
        hold = 1'b0;
        id_pc = 32'h5000;
        step();
        chk("release_pc", ex_pc, 32'h5000);
        chk("release_rd", ex_rd, 5'd11);

        // invalid ID zeroes controls but carries data
        set_id(1'b0, 2'b01, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12);
        id_mw = 1'b1; id_aop = 5'h07; id_pc = 32'h6000;
        step();
        chk("inv_ctrl", {ex_valid, ex_rw, ex_mw, ex_aop, ex_wd}, 0);
        chk("inv_pc", ex_pc, 32'h6000);

        // saturate the bubble counter
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 2'b01, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4);
            step();
            set_id(1'b1, 2'b00, 5'd4, 1'b1, 5'd0, 1'b0, 5'd6);
            step();
        end
        chk("sat_cnt", cnt, 2'd3);

        // reset overrides flush/hold
        rst = 1'b1; flush = 1'b1; hold = 1'b1;
        step();
        chk("rst2_cnt", cnt, 0);
        chk("rst2_valid", ex_valid, 0);
        rst = 1'b0; flush = 1'b0; hold = 1'b0;

        // reset in the middle of a stall
        set_id(1'b1, 2'b01, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5);
        step();
        set_id(1'b1, 2'b00, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
        #1 chk("mid_stall", stall, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 chk("mid_stall_cleared", stall, 0);
        step();
        chk("mid_capture", {ex_valid, ex_rd}, {1'b1, 5'd6});
        chk("mid_cnt", cnt, 0);

        // mixed traffic against the model
        for (int i = 0; i < 60; i++) begin
            set_id(1'($urandom), 2'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), 5'($urandom_range(0, 3)));
            id_aop = 5'($urandom);
            id_mw = 1'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            hold = ($urandom_range(0, 4) == 0);
            step();
        end
        flush = 1'b0; hold = 1'b0;
        step();
        cmp_on = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DW, 32, datapath width of pc/operand/immediate fields.
REQ-002 Parameter CNT_W, 16, width of load-use bubble counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid_i  in  1  ID slot holds a real instruction.
REQ-006 id_RegWrite_i, id_MemWrite_i, id_ALUSrc_i  in  1 each  decoder controls.
REQ-007 id_ALUOp_i  in  5  ALU operation from decoder.
REQ-008 id_NPCOp_i  in  3  next-PC operation from decoder.
REQ-009 id_WDSel_i  in  2  writeback select; 2'b01 = load.
REQ-010 id_DMType_i  in  3  data-memory access type.
REQ-011 id_pc_i, id_rd1_i, id_rd2_i, id_imm_i  in  DW each  PC, register operands, extended immediate.
REQ-012 id_rs1_i, id_rs2_i, id_rd_i  in  5 each  register indices.
REQ-013 id_use_rs1_i, id_use_rs2_i  in  1 each  ID instruction reads rs1/rs2.
REQ-014 flush_i  in  1  kill ID instruction (branch/jump redirect).
REQ-015 hold_i  in  1  freeze stage (downstream not ready).
REQ-016 ex_* outputs  out  same widths as id_* counterparts (valid, RegWrite, MemWrite, ALUSrc, ALUOp, NPCOp, WDSel, DMType, pc, rd1, rd2, imm, rs1, rs2, rd)  registered EX-stage copy.
REQ-017 load_use_stall_o  out  1  combinational; upstream PC and IF/ID shall hold.
REQ-018 bubble_cnt_o  out  CNT_W  count of load-use bubbles inserted.

Function
REQ-019 Latency: one cycle; a captured ID entry appears on ex_* the cycle after the edge.
REQ-020 Hazard: load_use_stall_o = id_valid_i & ~flush_i & ex_valid & (ex_WDSel==2'b01) & (ex_rd!=0) & ((id_use_rs1_i & id_rs1_i==ex_rd) | (id_use_rs2_i & id_rs2_i==ex_rd)).
REQ-021 Per-edge priority: rst > flush_i > hold_i > load_use_stall_o > capture.
REQ-022 Flush: ex_valid and all ex control outputs (RegWrite, MemWrite, ALUSrc, ALUOp, NPCOp, WDSel, DMType) become 0; data/index fields unchanged; flush overrides hold_i.
REQ-023 Hold (no flush): every ex_* register keeps its value; bubble_cnt_o unchanged.
REQ-024 Load-use bubble (no flush, no hold): same clearing as REQ-022; bubble_cnt_o increments by 1.
REQ-025 Capture: all ex_* registers load id_* inputs; if id_valid_i=0, control outputs load 0 regardless of id_* control inputs.
REQ-026 ex_valid=0 shall always imply ex_RegWrite=0 and ex_MemWrite=0.
REQ-027 bubble_cnt_o saturates at 2^CNT_W-1; no wrap-around.
REQ-028 Hazard compare never matches on rd=x0.

Reset
REQ-029 On rst=1 at an edge: all ex_* outputs and bubble_cnt_o become 0, overriding flush_i/hold_i.
REQ-030 Reset mid-stall: the next edge after rst deasserts performs a normal capture; load_use_stall_o depends only on current inputs and is 0 while ex_valid=0.

Verification
REQ-031 Capture: id_valid=1, RegWrite=1, ALUOp=5'h03, rd1=32'h11, rd=5 -> next cycle ex_valid=1, ex_ALUOp=5'h03, ex_rd1=32'h11, ex_rd=5.
REQ-032 Load-use: EX holds lw x5 (WDSel=01, valid); ID add with rs1=5, use_rs1=1 -> load_use_stall_o=1; next cycle ex_valid=0, ex_RegWrite=0, bubble_cnt_o=1; following cycle add captured.
REQ-033 x0/no-use: EX load with rd=0, or ID rs2=5 with use_rs2=0 -> load_use_stall_o=0, no bubble, count unchanged.
REQ-034 Flush+hold same cycle with valid ID -> ex_valid=0, controls 0, bubble_cnt_o unchanged, load_use_stall_o=0.
REQ-035 Hold 3 cycles with changing id_* -> ex_* constant; release -> capture of current id_*.
REQ-036 Saturation with CNT_W=2: four consecutive load-use bubbles -> bubble_cnt_o = 3; rst -> 0.
